// File: rtl/spi_ram.sv
// Purpose: command-driven byte RAM behind an SPI slave. It keeps independent write and read pointers that auto-increment and wrap.
// Latency: read data is registered, so tx_valid/tx_data appear one clock after the edge that samples opcode 11.
// Backpressure: none. A command is consumed on every edge where rx_valid=1. Read data is a one-cycle tx_valid pulse that the SPI slave must capture.
//
// Ports:
//   clk       - single clock; all state changes on the rising edge
//   rst       - asynchronous active-high reset (clears pointers, arm flags and outputs, not the memory)
//   rx_valid  - rx_data holds a complete command this cycle
//   rx_data   - [9:8] opcode, [7:0] payload
//   tx_valid  - one-cycle strobe: tx_data holds read data
//   tx_data   - read data; holds its last value while tx_valid=0
//   seq_err   - one-cycle pulse: data command issued before its address was loaded

module spi_ram #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [9:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       seq_err
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef struct packed {
    opcode_e    op;
    logic [7:0] payload;
  } cmd_t;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  // An address loaded from the bus may exceed a non-power-of-two depth.
  // It is folded into range once, at load time, so the pointers are always valid.
  function automatic logic [ADDR_SIZE-1:0] fold_addr(input logic [ADDR_SIZE-1:0] a);
    int unsigned v;
    v = 32'(a) % MEM_DEPTH;
    return ADDR_SIZE'(v);
  endfunction

  // Increment that wraps at the top of the implemented depth rather than at 2**ADDR_SIZE.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  cmd_t                 cmd;
  logic [ADDR_SIZE-1:0] load_addr;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_armed;
  logic                 rd_armed;
  logic                 mem_we;
  logic [7:0]           mem [0:MEM_DEPTH-1];

  assign cmd       = cmd_t'(rx_data);
  assign load_addr = fold_addr(rx_data[ADDR_SIZE-1:0]);
  assign mem_we    = rx_valid && (cmd.op == OP_WR_DATA) && wr_armed;

  // The storage array has no reset, so its contents survive rst.
  // Writes are blocked while rst is held, so a command issued during reset is dropped here as well.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[wr_addr] <= cmd.payload;
    end
  end

  // Pointers, arm flags and registered outputs.
  // tx_valid and seq_err default low every edge, which makes each of them a single-cycle pulse per command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      seq_err  <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_armed <= 1'b0;
      rd_armed <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      seq_err  <= 1'b0;
      if (rx_valid) begin
        unique case (cmd.op)
          OP_WR_ADDR: begin
            wr_addr  <= load_addr;
            wr_armed <= 1'b1;
          end
          OP_WR_DATA: begin
            if (wr_armed) begin
              wr_addr <= next_addr(wr_addr);
            end else begin
              seq_err <= 1'b1;
            end
          end
          OP_RD_ADDR: begin
            rd_addr  <= load_addr;
            rd_armed <= 1'b1;
          end
          OP_RD_DATA: begin
            // The array read sees any write committed on an earlier edge.
            // A read that directly follows a write to the same address therefore returns the new byte.
            if (rd_armed) begin
              tx_data  <= mem[rd_addr];
              tx_valid <= 1'b1;
              rd_addr  <= next_addr(rd_addr);
            end else begin
              seq_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit memory words.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address width; MEM_DEPTH <= 2**ADDR_SIZE.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port rx_valid  input  1  rx_data holds a complete command this cycle, from the SPI slave.
REQ-006 SHALL have port rx_data  input  10  command: [9:8] opcode, [7:0] payload.
REQ-007 SHALL have port tx_valid  output  1  tx_data holds read data for the SPI slave to shift out on MISO.
REQ-008 SHALL have port tx_data  output  8  read data.
REQ-009 SHALL have port seq_err  output  1  one-cycle pulse: data command issued with no address loaded.

Function
REQ-010 SHALL act only at rising clk edges where rx_valid=1; rx_valid=0 -> no state change except REQ-018.
REQ-011 Opcode 00 (write address) SHALL load wr_addr <= rx_data[ADDR_SIZE-1:0] and set wr_armed=1.
REQ-012 Opcode 01 (write data) with wr_armed=1 SHALL write mem[wr_addr] <= rx_data[7:0], then wr_addr <= wr_addr+1.
REQ-013 Opcode 10 (read address) SHALL load rd_addr <= rx_data[ADDR_SIZE-1:0] and set rd_armed=1.
REQ-014 Opcode 11 (read data) with rd_armed=1 SHALL register tx_data <= mem[rd_addr], tx_valid <= 1 at that edge, then rd_addr <= rd_addr+1.
REQ-015 Latency SHALL be exactly one clock: tx_valid high in the cycle after the sampling edge of opcode 11.
REQ-016 tx_valid SHALL be high for exactly one cycle per accepted read; back-to-back read commands SHALL give consecutive tx_valid cycles with successive addresses.
REQ-017 tx_data SHALL hold its last value while tx_valid=0.
REQ-018 tx_valid and seq_err SHALL return to 0 on the edge after they were asserted unless re-asserted by a new command.
REQ-019 Opcode 01 with wr_armed=0 or opcode 11 with rd_armed=0 SHALL pulse seq_err for one cycle, no memory write, tx_valid stays 0, addresses unchanged.
REQ-020 Address increment SHALL wrap: MEM_DEPTH-1 -> 0 (applies to both wr_addr and rd_addr).
REQ-021 Loaded address >= MEM_DEPTH SHALL be reduced modulo MEM_DEPTH at load.
REQ-022 wr_armed and rd_armed SHALL stay set until reset; write and read pointers SHALL be independent.
REQ-023 Read of the address written by the immediately preceding command SHALL return the new data.
REQ-024 A new address command SHALL override the pointer regardless of outstanding increments.
REQ-025 Memory SHALL be a single-write, single-read synchronous array; at most one command per cycle so no write/read conflict exists.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force tx_valid=0, tx_data=8'h00, seq_err=0, wr_addr=0, rd_addr=0, wr_armed=0, rd_armed=0.
REQ-027 Memory contents SHALL be preserved across reset and are undefined after power-up.
REQ-028 rst asserted while tx_valid=1 SHALL drop tx_valid in the same cycle; the read is lost.
REQ-029 Commands with rx_valid=1 while rst=1 SHALL be ignored.
REQ-030 After rst deasserts, first command SHALL be accepted at the first rising edge.

Verification
REQ-031 Write 00_10, 01_A5, then 10_10, 11_xx -> tx_valid=1 one cycle after the read edge, tx_data=8'hA5.
REQ-032 Write 00_FF, 01_11, 01_22 (MEM_DEPTH=256) -> mem[FF]=11, mem[00]=22; reading 10_FF, 11, 11 -> tx_data 11 then 22 in consecutive cycles.
REQ-033 After reset, 11_xx -> seq_err=1 one cycle, tx_valid=0; 01_55 -> seq_err=1, no memory change.
REQ-034 Write 00_20, 01_66, reset, 10_20, 11_xx -> tx_data=8'h66 (memory retained, pointers cleared).
REQ-035 Assert rst in the cycle tx_valid=1 -> tx_valid=0 and tx_data=8'h00 immediately, no further tx_valid.
REQ-036 rx_valid=0 with opcode 11 on rx_data for 10 cycles -> no tx_valid, no seq_err, pointers unchanged.
